// File: rtl/mem_arb_pkg.sv
// Shared types and width constants for the dcache/icache to RAM arbiter.
package mem_arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int BCNT_W = 4;
  localparam int STAT_W = 32;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    DOWN = 2'b01,
    IOWN = 2'b10
  } owner_t;

endpackage

// File: rtl/arb_burst_ctr.sv
// Counts consecutive dcache completions while the icache waits and raises
// forced once the icache must be granted next.
module arb_burst_ctr
  import mem_arb_pkg::*;
#(
  parameter int DBURST_MAX = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic iren,
  input  logic dcomp,
  input  logic icomp,
  output logic forced
);

  localparam logic [BCNT_W-1:0] MAX = BCNT_W'(DBURST_MAX);

  logic [BCNT_W-1:0] count_reg;
  logic [BCNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (icomp || !iren) begin
      count_next = '0;
    end else if (dcomp && (count_reg != MAX)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Looking at the post-update count lets the completion that reaches the
  // limit hand the port straight to the icache.
  assign forced = iren && (count_next == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates dcache and icache single-word requests onto one RAM port.
// Define MEM_ARB_STATS_EN to add the dgrants/igrants/stalls counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DBURST_MAX = 4,
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [AW-1:0]     iaddr,
  output logic              iwait,
  output logic [DW-1:0]     iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [AW-1:0]     daddr,
  input  logic [DW-1:0]     dstore,
  output logic              dwait,
  output logic [DW-1:0]     dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [AW-1:0]     ramaddr,
  output logic [DW-1:0]     ramstore,
  input  logic [DW-1:0]     ramload,
`ifdef MEM_ARB_STATS_EN
  output logic [STAT_W-1:0] dgrants,
  output logic [STAT_W-1:0] igrants,
  output logic [STAT_W-1:0] stalls,
`endif
  input  ramstate_t         ramstate
);

  owner_t owner_reg;
  owner_t owner_next;
  logic   dreq;
  logic   own_req;
  logic   done;
  logic   dcomp;
  logic   icomp;
  logic   forced;

  assign dreq = dREN | dWEN;

  always_comb begin
    own_req = 1'b0;
    case (owner_reg)
      DOWN:    own_req = dreq;
      IOWN:    own_req = iREN;
      default: own_req = 1'b0;
    endcase
  end

  // A reset cycle never completes, so an abandoned transfer gives no pulse.
  assign done  = own_req && (ramstate == ACCESS) && !RST;
  assign dcomp = done && (owner_reg == DOWN);
  assign icomp = done && (owner_reg == IOWN);

  arb_burst_ctr #(
    .DBURST_MAX(DBURST_MAX)
  ) u_burst (
    .clk   (CLK),
    .srst  (RST),
    .iren  (iREN),
    .dcomp (dcomp),
    .icomp (icomp),
    .forced(forced)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_reg <= NONE;
    end else begin
      owner_reg <= owner_next;
    end
  end

  always_comb begin
    owner_next = owner_reg;
    if ((owner_reg == NONE) || done) begin
      if (dreq && !forced) begin
        owner_next = DOWN;
      end else if (iREN) begin
        owner_next = IOWN;
      end else begin
        owner_next = NONE;
      end
    end else if (!own_req) begin
      owner_next = NONE;
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (owner_reg)
      DOWN: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      IOWN: begin
        ramaddr = iaddr;
        ramREN  = iREN;
      end
      default: ;
    endcase
  end

  assign dwait = ~dcomp;
  assign iwait = ~icomp;
  assign dload = ramload;
  assign iload = ramload;

`ifdef MEM_ARB_STATS_EN
  logic [2:0]        stat_inc;
  logic [STAT_W-1:0] stat_reg [3];

  assign stat_inc[0] = dcomp;
  assign stat_inc[1] = icomp;
  assign stat_inc[2] = (dreq && (owner_reg != DOWN)) || (iREN && (owner_reg != IOWN));

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    always_ff @(posedge CLK) begin
      if (RST) begin
        stat_reg[gi] <= '0;
      end else if (stat_inc[gi]) begin
        stat_reg[gi] <= stat_reg[gi] + 1'b1;
      end
    end
  end

  assign dgrants = stat_reg[0];
  assign igrants = stat_reg[1];
  assign stalls  = stat_reg[2];
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: stimulus pushes expected completions, a negedge monitor
// pops and checks every wait pulse against them.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] dgrants, igrants, stalls;
`endif

  typedef struct {
    logic        is_i;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.DBURST_MAX(4), .AW(32), .DW(32)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
`ifdef MEM_ARB_STATS_EN
    .dgrants (dgrants),
    .igrants (igrants),
    .stalls  (stalls),
`endif
    .ramstate(ramstate)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_i, input logic [31:0] addr, input logic wen,
                      input logic [31:0] data);
    exp_t e;
    e.is_i = is_i;
    e.addr = addr;
    e.wen  = wen;
    e.data = data;
    sb.push_back(e);
  endtask

  // Inputs change 1 ns after the edge, checks run at edge+3, monitor at negedge.
  task automatic drive(input ramstate_t st, input logic [31:0] ld);
    ramstate = st;
    ramload  = ld;
    #2;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive(FREE, 32'h0);
      tick();
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (dwait === 1'b0 || iwait === 1'b0) begin
      if (dwait === 1'b0 && iwait === 1'b0) begin
        checks++;
        errors++;
        $display("FAIL both_waits_low dwait=%b iwait=%b required=one_low", dwait, iwait);
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse dwait=%b iwait=%b addr=%h required=no_pulse",
                 dwait, iwait, ramaddr);
      end else begin
        e = sb.pop_front();
        chk("pulse_is_icache", {31'b0, iwait === 1'b0}, {31'b0, e.is_i});
        chk("pulse_ramaddr", ramaddr, e.addr);
        chk("pulse_ramWEN", {31'b0, ramWEN}, {31'b0, e.wen});
        chk("pulse_load", e.is_i ? iload : dload, e.data);
      end
    end
  end

  initial begin
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    tick();
    tick();
    RST = 1'b0;
    drive(FREE, 32'h0);
    chk("reset_ramREN", {31'b0, ramREN}, 32'h0);
    chk("reset_ramWEN", {31'b0, ramWEN}, 32'h0);
    chk("reset_ramaddr", ramaddr, 32'h0);
    chk("reset_waits", {30'b0, iwait, dwait}, 32'h3);
    tick();

    // Simultaneous requests: dcache first, icache after dcache releases.
    dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h40;
    drive(BUSY, 32'h0);
    chk("t1_none_ramREN", {31'b0, ramREN}, 32'h0);
    tick();
    drive(BUSY, 32'h0);
    chk("t1_ramaddr", ramaddr, 32'h100);
    chk("t1_ramREN", {31'b0, ramREN}, 32'h1);
    tick();
    push(1'b0, 32'h100, 1'b0, 32'h1234_5678);
    drive(ACCESS, 32'h1234_5678);
    tick();
    dREN = 1'b0;
    drive(BUSY, 32'h0);
    tick();
    drive(BUSY, 32'h0);
    tick();
    drive(BUSY, 32'h0);
    chk("t1_iaddr", ramaddr, 32'h40);
    chk("t1_iwait_busy", {31'b0, iwait}, 32'h1);
    tick();
    push(1'b1, 32'h40, 1'b0, 32'h0BAD_F00D);
    drive(ACCESS, 32'h0BAD_F00D);
    tick();
    idle(2);

    // Burst limit: four dcache completions, then a forced icache grant.
    dREN = 1'b1; daddr = 32'h300; iREN = 1'b1; iaddr = 32'h44;
    drive(ACCESS, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      push(1'b0, 32'h300, 1'b0, 32'hB000_0000 + k);
      drive(ACCESS, 32'hB000_0000 + k);
      tick();
    end
    push(1'b1, 32'h44, 1'b0, 32'hC000_0001);
    drive(ACCESS, 32'hC000_0001);
    chk("t2_forced_iaddr", ramaddr, 32'h44);
    tick();
    push(1'b0, 32'h300, 1'b0, 32'hB000_0010);
    drive(ACCESS, 32'hB000_0010);
    tick();
    idle(2);

    // Write, with dREN also set: write wins.
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
    drive(BUSY, 32'h0);
    tick();
    drive(BUSY, 32'h0);
    chk("t3_ramWEN", {31'b0, ramWEN}, 32'h1);
    chk("t3_ramREN", {31'b0, ramREN}, 32'h0);
    chk("t3_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("t3_ramaddr", ramaddr, 32'h200);
    tick();
    push(1'b0, 32'h200, 1'b1, 32'h5555_AAAA);
    drive(ACCESS, 32'h5555_AAAA);
    tick();
    idle(2);

    // ERROR is retried while the owner holds.
    dREN = 1'b1; daddr = 32'h400;
    drive(ERROR, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(ERROR, 32'h0);
      chk("t4_err_dwait", {31'b0, dwait}, 32'h1);
      chk("t4_err_ramREN", {31'b0, ramREN}, 32'h1);
      tick();
    end
    push(1'b0, 32'h400, 1'b0, 32'h7777_0004);
    drive(ACCESS, 32'h7777_0004);
    tick();
    idle(2);

    // Request withdrawn mid-transfer, then the pending icache is granted.
    dREN = 1'b1; daddr = 32'h500; iREN = 1'b1; iaddr = 32'h48;
    drive(BUSY, 32'h0);
    tick();
    drive(BUSY, 32'h0);
    tick();
    dREN = 1'b0;
    drive(ACCESS, 32'h0);
    chk("t5_drop_ramREN", {31'b0, ramREN}, 32'h0);
    chk("t5_drop_dwait", {31'b0, dwait}, 32'h1);
    tick();
    drive(BUSY, 32'h0);
    chk("t5_none_ramREN", {31'b0, ramREN}, 32'h0);
    chk("t5_none_ramaddr", ramaddr, 32'h0);
    tick();
    push(1'b1, 32'h48, 1'b0, 32'h4848_4848);
    drive(ACCESS, 32'h4848_4848);
    tick();
    idle(2);

`ifdef MEM_ARB_STATS_EN
    drive(FREE, 32'h0);
    chk("stats_dgrants", dgrants, 32'd8);
    chk("stats_igrants", igrants, 32'd3);
    tick();
`endif

    // Reset while the dcache owns the port and RAM is busy.
    dREN = 1'b1; daddr = 32'h600;
    drive(BUSY, 32'h0);
    tick();
    drive(BUSY, 32'h0);
    chk("t6_pre_ramREN", {31'b0, ramREN}, 32'h1);
    tick();
    RST = 1'b1;
    drive(ACCESS, 32'h0);
    tick();
    RST = 1'b0;
    drive(BUSY, 32'h0);
    chk("t6_ramREN", {31'b0, ramREN}, 32'h0);
    chk("t6_ramWEN", {31'b0, ramWEN}, 32'h0);
    chk("t6_ramaddr", ramaddr, 32'h0);
    chk("t6_ramstore", ramstore, 32'h0);
    chk("t6_waits", {30'b0, iwait, dwait}, 32'h3);
`ifdef MEM_ARB_STATS_EN
    chk("t6_dgrants", dgrants, 32'h0);
    chk("t6_igrants", igrants, 32'h0);
    chk("t6_stalls", stalls, 32'h0);
`endif
    tick();
    idle(3);

    chk("sb_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the dcache control unit and the icache. Arbitrates their single-word read/write requests onto the one RAM port.
- Generates the per-cache wait handshakes (iwait/dwait) and returns load data.
- Dcache has priority. A burst counter prevents icache starvation.
- Ownership is registered, so completion of one transfer can hand over to the next requester with zero bubble cycles.

Parameters:
- DBURST_MAX, 4: maximum consecutive dcache completions while iREN is pending before the icache is forced a grant (range 1..15).
- AW, 32: address width.
- DW, 32: data width.

Ports:
- CLK in 1: clock, rising edge.
- RST in 1: reset, synchronous, active-high.
- iREN in 1: icache read request.
- iaddr in AW: icache word address.
- iwait out 1: low for exactly the cycle the icache read completes.
- iload out DW: icache read data, valid when iwait=0.
- dREN in 1: dcache read request.
- dWEN in 1: dcache write request.
- daddr in AW: dcache word address.
- dstore in DW: dcache write data.
- dwait out 1: low for exactly the cycle the dcache access completes.
- dload out DW: dcache read data, valid when dwait=0.
- ramREN out 1: RAM read enable.
- ramWEN out 1: RAM write enable.
- ramaddr out AW: RAM address.
- ramstore out DW: RAM write data.
- ramload in DW: RAM read data.
- ramstate in 2: RAM status; FREE, BUSY, ACCESS or ERROR.

Behaviour:
- Owner state register: NONE, DOWN, IOWN.
- Reset (RST high at a CLK edge, also mid-transfer):
  - owner=NONE, burst count=0.
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=dwait=1.
  - Any in-flight transfer is abandoned with no completion pulse.
- RAM drive is combinational from owner:
  - DOWN: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. Write wins if both are set.
  - IOWN: ramaddr=iaddr, ramREN=iREN, ramWEN=0.
  - NONE: all RAM outputs 0.
- Completion is owner's request active AND ramstate==ACCESS.
  - dwait=~(DOWN & completion); iwait=~(IOWN & completion).
  - iload=dload=ramload at all times.
- Next owner is evaluated when owner=NONE, or in a completion cycle. Let dreq=dREN|dWEN.
  - dreq and not forced: DOWN.
  - iREN: IOWN.
  - Otherwise: NONE.
  - Forced means iREN & (burst count==DBURST_MAX).
- Not completing and the owner's request is still high: owner holds. ramstate BUSY or ERROR means wait; ERROR is retried indefinitely.
- Owner's request drops before completion: owner becomes NONE next cycle, with no completion pulse. Re-arbitration starts from NONE.
- Burst count (4 bits):
  - Increments on each dcache completion while iREN=1.
  - Clears on any icache completion, or when iREN=0.
  - Saturates at DBURST_MAX.
- No combinational path from ramload to any RAM output.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- When defined:
  - Adds output ports dgrants (32), igrants (32) and stalls (32).
  - dgrants and igrants count completions per requester.
  - stalls counts cycles where a request is pending but not owned.
  - All counters clear on RST and wrap modulo 2^32.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - ramstate_t enum: FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11.
  - owner_t enum: NONE, DOWN, IOWN.
  - Width constants.
- One natural sub-module, arb_burst_ctr: burst counter and forced-grant flag, parameterised by DBURST_MAX.
- The FSM and muxing stay in mem_arbiter.

Test Plan:
- dREN=1 at daddr=0x100 and iREN=1 at iaddr=0x40 in the same cycle; RAM ACCESS after 2 BUSY cycles -> ramaddr=0x100 first; dwait=0 for one cycle in cycle 3 with dload=ramload; icache is granted next (dREN dropped) and iwait stays 1 until its ACCESS.
- Continuous dREN with iREN pending, single-cycle ACCESS, DBURST_MAX=4 -> four dwait=0 pulses, then ramaddr=iaddr with iwait=0. Count resets; dcache resumes on the next cycle.
- Dcache write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF until ACCESS; dwait pulses once.
- ramstate=ERROR for 3 cycles, then ACCESS -> owner held, no waits deasserted during ERROR, single completion pulse afterwards.
- dREN dropped mid-BUSY -> next cycle owner=NONE, ramREN=0, no dwait pulse; a pending iREN is granted the following cycle.
- RST asserted while owner=DOWN and BUSY -> next cycle all RAM outputs 0, iwait=dwait=1; with MEM_ARB_STATS_EN, all counters read 0.
